// File: rtl/vga_pattern_gen.sv
// Test-pattern stage behind hvsync: renders bars/checker/box/solid colour and
// delays the syncs so that colour and sync stay aligned on the VGA pins.
module vga_pattern_gen #(
  parameter int   H_ACTIVE    = 640,
  parameter int   V_ACTIVE    = 480,
  parameter int   BOX_SIZE    = 32,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       display_on,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic [1:0] mode,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);

  localparam int         BAR_W = H_ACTIVE / 8;
  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] BOX_W = 11'(BOX_SIZE);

  logic        hsync1_q, hsync2_q, vsync1_q, vsync2_q;
  logic        disp_q, disp_d;
  logic [9:0]  hpos_q, hpos_d, vpos_q, vpos_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic        checker_q, checker_d;
  logic        vdet_q, vdet_prev_q;
  logic        frame_tick;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [9:0]  box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic        box_hit;
  logic [11:0] rgb_q, rgb_d;

  function automatic logic [11:0] table_rgb(input logic [2:0] i);
    return {{4{~i[1]}}, {4{~i[2]}}, {4{~i[0]}}};
  endfunction

  // Stage 1: capture the pixel and derive the position-only pattern flags.
  always_comb begin
    disp_d    = display_on;
    hpos_d    = hpos;
    vpos_d    = vpos;
    checker_d = hpos[5] ^ vpos[5];
    bar_idx_d = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(hpos) >= k * BAR_W) bar_idx_d = 3'(k);
    end
  end

  // The detector keeps its own vsync copy, reset to the active level, so a
  // vsync held active across reset release cannot fake an edge.
  assign frame_tick = (vdet_q == SYNC_ACTIVE) && (vdet_prev_q != SYNC_ACTIVE);

  always_comb begin
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    if (frame_tick) begin
      mode_d      = mode;
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (dx_q && box_x_q == X_MAX) begin
        dx_d    = 1'b0;
        box_x_d = box_x_q - 10'd1;
      end else if (!dx_q && box_x_q == 10'd0) begin
        dx_d    = 1'b1;
        box_x_d = 10'd1;
      end else begin
        box_x_d = dx_q ? box_x_q + 10'd1 : box_x_q - 10'd1;
      end
      if (dy_q && box_y_q == Y_MAX) begin
        dy_d    = 1'b0;
        box_y_d = box_y_q - 10'd1;
      end else if (!dy_q && box_y_q == 10'd0) begin
        dy_d    = 1'b1;
        box_y_d = 10'd1;
      end else begin
        box_y_d = dy_q ? box_y_q + 10'd1 : box_y_q - 10'd1;
      end
    end
  end

  assign box_hit = (hpos_q >= box_x_q) && ({1'b0, hpos_q} < {1'b0, box_x_q} + BOX_W) &&
                   (vpos_q >= box_y_q) && ({1'b0, vpos_q} < {1'b0, box_y_q} + BOX_W);

  // Stage 2: final colour, forced to black outside the visible area.
  always_comb begin
    rgb_d = 12'h000;
    if (disp_q) begin
      case (mode_q)
        2'd0:    rgb_d = table_rgb(bar_idx_q);
        2'd1:    rgb_d = checker_q ? 12'h000 : 12'hFFF;
        2'd2:    rgb_d = box_hit ? 12'hFFF : 12'h004;
        default: rgb_d = table_rgb(frame_cnt_q[7:5]);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync1_q    <= ~SYNC_ACTIVE;
      hsync2_q    <= ~SYNC_ACTIVE;
      vsync1_q    <= ~SYNC_ACTIVE;
      vsync2_q    <= ~SYNC_ACTIVE;
      disp_q      <= 1'b0;
      hpos_q      <= 10'd0;
      vpos_q      <= 10'd0;
      bar_idx_q   <= 3'd0;
      checker_q   <= 1'b0;
      vdet_q      <= SYNC_ACTIVE;
      vdet_prev_q <= SYNC_ACTIVE;
      mode_q      <= 2'd0;
      frame_cnt_q <= 8'd0;
      box_x_q     <= 10'd0;
      box_y_q     <= 10'd0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      rgb_q       <= 12'h000;
    end else begin
      hsync1_q    <= hsync_in;
      hsync2_q    <= hsync1_q;
      vsync1_q    <= vsync_in;
      vsync2_q    <= vsync1_q;
      disp_q      <= disp_d;
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      bar_idx_q   <= bar_idx_d;
      checker_q   <= checker_d;
      vdet_q      <= vsync_in;
      vdet_prev_q <= vdet_q;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      rgb_q       <= rgb_d;
    end
  end

  assign hsync_out = hsync2_q;
  assign vsync_out = vsync2_q;
  assign r = rgb_q[11:8];
  assign g = rgb_q[7:4];
  assign b = rgb_q[3:0];

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: default-size instance plus a shrunken
// 64x48 instance (fixed in box mode) for the bounce behaviour.
module tb_vga_pattern_gen;

  logic       clk = 1'b0;
  logic       reset, hsync_in, vsync_in, display_on;
  logic [9:0] hpos, vpos;
  logic [1:0] mode;
  logic       hs_o, vs_o, s_hs, s_vs;
  logic [3:0] r, g, b, s_r, s_g, s_b;
  int         total = 0;
  int         bad = 0;
  int         exp_cnt;
  logic [9:0]  bar_h [8];
  logic [11:0] bar_c [8];

  vga_pattern_gen dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .display_on(display_on), .hpos(hpos), .vpos(vpos), .mode(mode),
    .hsync_out(hs_o), .vsync_out(vs_o), .r(r), .g(g), .b(b)
  );

  vga_pattern_gen #(.H_ACTIVE(64), .V_ACTIVE(48), .BOX_SIZE(16)) dut_s (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .display_on(display_on), .hpos(hpos), .vpos(vpos), .mode(2'd2),
    .hsync_out(s_hs), .vsync_out(s_vs), .r(s_r), .g(s_g), .b(s_b)
  );

  always #20 clk = ~clk;

  task automatic stepClk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v, input logic disp);
    hpos = h;
    vpos = v;
    display_on = disp;
    stepClk(2);
  endtask

  // Inactive then active vsync; the state update lands on the third edge.
  task automatic frameTick();
    vsync_in = 1'b1;
    stepClk(1);
    vsync_in = 1'b0;
    stepClk(2);
  endtask

  function automatic logic [11:0] expColour(input int idx);
    case (idx)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  initial begin
    reset = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; display_on = 1'b0;
    hpos = '0; vpos = '0; mode = 2'd0;
    stepClk(3);
    checkOutput("reset_rgb", 32'({r, g, b}), 32'h000);
    checkOutput("reset_hs", 32'(hs_o), 32'd1);
    checkOutput("reset_vs", 32'(vs_o), 32'd1);
    reset = 1'b1;
    stepClk(3);
    checkOutput("post_reset_cnt", 32'(dut.frame_cnt_q), 32'd0);

    // Colour bars with mode 0 latched.
    frameTick();
    bar_h = '{10'd0, 10'd79, 10'd80, 10'd160, 10'd320, 10'd559, 10'd560, 10'd639};
    bar_c = '{12'hFFF, 12'hFFF, 12'hFF0, 12'h0FF, 12'hF0F, 12'h00F, 12'h000, 12'h000};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(bar_h[i], 10'd100, 1'b1);
      checkOutput($sformatf("bar_h%0d", bar_h[i]), 32'({r, g, b}), 32'(bar_c[i]));
    end

    // Blank and hsync change together and must emerge together.
    hpos = 10'd0; display_on = 1'b1; hsync_in = 1'b1;
    stepClk(3);
    display_on = 1'b0; hsync_in = 1'b0;
    stepClk(1);
    checkOutput("align_rgb_1", 32'({r, g, b}), 32'hFFF);
    checkOutput("align_hs_1", 32'(hs_o), 32'd1);
    stepClk(1);
    checkOutput("align_rgb_2", 32'({r, g, b}), 32'h000);
    checkOutput("align_hs_2", 32'(hs_o), 32'd0);
    hsync_in = 1'b1;

    // Mode change mid-frame waits for the next vsync edge.
    vsync_in = 1'b1;
    mode = 2'd1;
    stepClk(5);
    applyStimulus(10'd80, 10'd0, 1'b1);
    checkOutput("latch_bar80", 32'({r, g, b}), 32'hFF0);
    applyStimulus(10'd32, 10'd0, 1'b1);
    checkOutput("latch_bar32", 32'({r, g, b}), 32'hFFF);
    frameTick();
    applyStimulus(10'd32, 10'd0, 1'b1);
    checkOutput("chk_32_0", 32'({r, g, b}), 32'h000);
    applyStimulus(10'd0, 10'd0, 1'b1);
    checkOutput("chk_0_0", 32'({r, g, b}), 32'hFFF);
    applyStimulus(10'd32, 10'd32, 1'b1);
    checkOutput("chk_32_32", 32'({r, g, b}), 32'hFFF);
    applyStimulus(10'd96, 10'd0, 1'b1);
    checkOutput("chk_96_0", 32'({r, g, b}), 32'h000);

    // Asynchronous reset mid-line with active syncs in flight.
    vsync_in = 1'b1;
    stepClk(1);
    hsync_in = 1'b0; vsync_in = 1'b0;
    applyStimulus(10'd0, 10'd0, 1'b1);
    stepClk(1);
    checkOutput("pre_reset_hs", 32'(hs_o), 32'd0);
    checkOutput("pre_reset_vs", 32'(vs_o), 32'd0);
    checkOutput("pre_reset_rgb", 32'({r, g, b}), 32'hFFF);
    #5 reset = 1'b0;
    #1;
    checkOutput("async_rgb", 32'({r, g, b}), 32'h000);
    checkOutput("async_hs", 32'(hs_o), 32'd1);
    checkOutput("async_vs", 32'(vs_o), 32'd1);
    stepClk(2);
    reset = 1'b1;
    stepClk(4);
    checkOutput("rel_cnt", 32'(dut.frame_cnt_q), 32'd0);
    checkOutput("rel_box_x", 32'(dut.box_x_q), 32'd0);
    checkOutput("rel_box_y", 32'(dut.box_y_q), 32'd0);
    applyStimulus(10'd32, 10'd0, 1'b1);
    checkOutput("rel_mode0", 32'({r, g, b}), 32'hFFF);
    hsync_in = 1'b1;

    // Box bounce on the 64x48 instance.
    for (int k = 1; k <= 40; k++) begin
      frameTick();
      if (k == 32) begin
        checkOutput("bounce32_y", 32'(dut_s.box_y_q), 32'd32);
        checkOutput("bounce32_dy", 32'(dut_s.dy_q), 32'd1);
      end
      if (k == 33) begin
        checkOutput("bounce33_y", 32'(dut_s.box_y_q), 32'd31);
        checkOutput("bounce33_dy", 32'(dut_s.dy_q), 32'd0);
      end
    end
    checkOutput("bounce40_x", 32'(dut_s.box_x_q), 32'd40);
    checkOutput("bounce40_y", 32'(dut_s.box_y_q), 32'd24);
    checkOutput("bounce40_cnt", 32'(dut.frame_cnt_q), 32'd40);
    applyStimulus(10'd40, 10'd24, 1'b1);
    checkOutput("box_tl", 32'({s_r, s_g, s_b}), 32'hFFF);
    applyStimulus(10'd39, 10'd24, 1'b1);
    checkOutput("box_left", 32'({s_r, s_g, s_b}), 32'h004);
    applyStimulus(10'd55, 10'd39, 1'b1);
    checkOutput("box_br", 32'({s_r, s_g, s_b}), 32'hFFF);
    applyStimulus(10'd56, 10'd24, 1'b1);
    checkOutput("box_right", 32'({s_r, s_g, s_b}), 32'h004);
    applyStimulus(10'd40, 10'd40, 1'b1);
    checkOutput("box_below", 32'({s_r, s_g, s_b}), 32'h004);

    // Solid colour over 256 frames, including the counter wrap.
    reset = 1'b0;
    stepClk(2);
    reset = 1'b1;
    mode = 2'd3;
    applyStimulus(10'd100, 10'd100, 1'b1);
    for (int k = 1; k <= 256; k++) begin
      frameTick();
      exp_cnt = k % 256;
      if ((k % 32 == 0) || (k % 32 == 31)) begin
        stepClk(2);
        checkOutput($sformatf("solid_f%0d", k), 32'({r, g, b}), 32'(expColour(exp_cnt / 32)));
      end
    end
    checkOutput("wrap_cnt", 32'(dut.frame_cnt_q), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
